// File: rtl/uarttx_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uarttx_pkg                                                            |
// | Shared types for the buffered UART transmitter: parity selection,     |
// | FSM states and a frame-length helper.                                 |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package uarttx_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
    PARITY_BIT = 3'd3,
    STOP_BIT   = 3'd4
  } state_e;

  // Number of bit periods in one frame: start + data + optional parity + stop.
  function automatic int frame_bits(input int data_bits, input parity_e parity,
                                    input int stop_bits);
    return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uarttx_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uarttx_fifo                                                           |
// | Single-clock synchronous FIFO with first-word fall-through read data. |
// | Full/empty come from the occupancy counter, pointers wrap naturally.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module uarttx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (PTR_W + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uarttx_buffered.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uarttx_buffered                                                       |
// | UART transmitter with a write FIFO, configurable data/parity/stop     |
// | format and a registered, glitch-free line output. Frames queued in    |
// | the FIFO go out back-to-back.                                         |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module uarttx_buffered
  import uarttx_pkg::*;
#(
  parameter int      ClockFrequencyHz = 66_000_000,
  parameter int      BaudRate         = 115200,
  parameter int      DataBits         = 8,
  parameter parity_e Parity           = PARITY_NONE,
  parameter int      StopBits         = 1,
  parameter int      FifoDepth        = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 wr_data,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(FifoDepth):0] fifo_count
);

  localparam int               BIT_TIME   = ClockFrequencyHz / BaudRate;
  localparam int               CNT_W      = (BIT_TIME > 2) ? $clog2(BIT_TIME) : 1;
  localparam logic [CNT_W-1:0] BIT_LOAD   = CNT_W'(BIT_TIME - 1);
  localparam logic [2:0]       LAST_DATA  = 3'(DataBits - 1);
  localparam logic [2:0]       LAST_STOP  = 3'(StopBits - 1);
  localparam int               FRAME_BITS = frame_bits(DataBits, Parity, StopBits);

  // Elaboration-time parameter sanity checks.
  if (BIT_TIME < 2) begin : g_chk_bit_time
    $error("uarttx_buffered: BIT_TIME must be at least 2");
  end
  if (DataBits < 5 || DataBits > 8) begin : g_chk_data_bits
    $error("uarttx_buffered: DataBits must be 5..8");
  end
  if (StopBits < 1 || StopBits > 2) begin : g_chk_stop_bits
    $error("uarttx_buffered: StopBits must be 1 or 2");
  end
  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_chk_depth
    $error("uarttx_buffered: FifoDepth must be a power of two >= 2");
  end
  if (FRAME_BITS > 12) begin : g_chk_frame
    $error("uarttx_buffered: frame longer than 12 bit periods");
  end

  state_e           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             par_bit;
  logic             active_d;
  logic [7:0]       fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             bit_end;
  logic             frame_end;
  logic             next_par;

  // Full is derived from the registered count, so a pop in the same cycle
  // never opens a slot for a write.
  assign wr_ready  = !fifo_full;
  assign push      = wr_valid && wr_ready;
  assign bit_end   = (bit_cnt == '0);
  assign frame_end = (state == STOP_BIT) && bit_end && (bit_idx == LAST_STOP);
  assign pop       = !fifo_empty && ((state == IDLE) || frame_end);
  assign next_par  = (^fifo_dout[DataBits-1:0]) ^ (Parity == PARITY_ODD);

  uarttx_fifo #(
    .WIDTH (8),
    .DEPTH (FifoDepth)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Frame sequencer: bit-time counter, bit index and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      if (pop) begin
        shreg   <= fifo_dout;
        par_bit <= next_par;
        bit_cnt <= BIT_LOAD;
        bit_idx <= '0;
        state   <= START_BIT;
      end else begin
        case (state)
          IDLE: begin
            state <= IDLE;
          end
          START_BIT: begin
            if (bit_end) begin
              bit_cnt <= BIT_LOAD;
              state   <= DATA_BITS;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
          DATA_BITS: begin
            if (bit_end) begin
              bit_cnt <= BIT_LOAD;
              shreg   <= {1'b0, shreg[7:1]};
              if (bit_idx == LAST_DATA) begin
                bit_idx <= '0;
                state   <= (Parity != PARITY_NONE) ? PARITY_BIT : STOP_BIT;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
          PARITY_BIT: begin
            if (bit_end) begin
              bit_cnt <= BIT_LOAD;
              bit_idx <= '0;
              state   <= STOP_BIT;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
          STOP_BIT: begin
            // The non-empty case of the final stop bit is handled by pop above.
            if (frame_end) begin
              state <= IDLE;
            end else if (bit_end) begin
              bit_cnt <= BIT_LOAD;
              bit_idx <= bit_idx + 1'b1;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Registered line driver; lags the sequencer by one cycle, idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx <= 1'b1;
    end else begin
      case (state)
        START_BIT:  tx <= 1'b0;
        DATA_BITS:  tx <= shreg[0];
        PARITY_BIT: tx <= par_bit;
        default:    tx <= 1'b1;
      endcase
    end
  end

  // Busy covers queued data, the sequencer, and the final registered line bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_d <= 1'b0;
      busy     <= 1'b0;
    end else begin
      active_d <= (state != IDLE);
      busy     <= push || !fifo_empty || (state != IDLE) || active_d;
    end
  end

endmodule
`default_nettype wire
